mpsk_symbol_mapper_tx: RTL and testbench
========================================

# mpsk_symbol_mapper_tx

Transmit-side MPSK baseband symbol mapper with optional differential encoding and rectangular-pulse upsampling. It accepts Gray-coded bit groups over a valid/ready handshake and maps each to a constant-amplitude I/Q constellation point. Each point is held for SPS consecutive output samples. It sits in front of the modulator/DAC path and generates the stimulus stream that the coherent demodulation chain decodes.

## Interface
- DATA_WIDTH, 16: signed width of out_i/out_q; amplitude A = 2^(DATA_WIDTH-1)-1.
- BITS_PER_SYM, 2: bits per symbol; legal values 1 (BPSK), 2 (QPSK), 3 (8PSK); M = 2^BITS_PER_SYM.
- SPS, 4: samples per symbol, legal range 1..256.
- DIFF_EN, 0: 1 enables differential phase encoding.
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_bits valid.
- in_bits  in  BITS_PER_SYM  Gray-coded symbol bits.
- in_ready  out  1  mapper can accept a symbol this cycle.
- out_valid  out  1  out_i/out_q carry a sample.
- out_i  out  DATA_WIDTH  signed in-phase sample.
- out_q  out  DATA_WIDTH  signed quadrature sample.
- out_sym_start  out  1  high on sample 0 of each symbol.

## Operation
- **Transfer:** a symbol transfers on a rising edge where in_valid && in_ready.
- **Index:** p = gray2bin(in_bits), so binary[msb] = gray[msb] and binary[i] = binary[i+1] ^ gray[i].
- **Differential encoding:**
  - DIFF_EN=1: transmitted index t = (acc + p) mod M, and acc <= t on each transfer.
  - acc resets to 0 on rstn only. It persists through IDLE.
  - DIFF_EN=0: t = p.
- **Constellation:**
  - angle = 2π·t/M.
  - out_i = round(A·cos(angle)), out_q = round(A·sin(angle)).
  - Values come from a constant LUT with round-half-away-from-zero.
  - For 16 bits: 0.7071·32767 → 23170.
- **States:**
  - **IDLE:** in_ready=1, out_valid=0, out_i=out_q=0.
    - On transfer: latch the point, sample_cnt=0, go to SEND.
  - **SEND:** out_valid=1. sample_cnt increments each cycle, and out_sym_start=1 when sample_cnt==0.
    - in_ready=1 only when sample_cnt==SPS-1.
    - At sample_cnt==SPS-1 with a transfer: load the new point, sample_cnt=0, stay in SEND (no gap).
    - At sample_cnt==SPS-1 without a transfer: go to IDLE.
- **in_ready:** combinational from registered state only, with no dependency on in_valid.
- **SPS=1:** in_ready is high every SEND cycle, giving one symbol per cycle at full rate.
- **in_bits stability:** in_bits is ignored whenever no transfer occurs. A producer that changes in_bits while in_ready=0 has no effect.
- **Reset (any time, including mid-symbol):**
  - state=IDLE, sample_cnt=0, acc=0.
  - out_valid=0, out_sym_start=0, out_i=out_q=0.
  - in_ready=0 while rstn=0 and 1 from the first cycle after release.

## Timing
- Outputs are registered. Latency from transfer edge to first sample is 1 cycle.
- Each symbol occupies exactly SPS consecutive out_valid cycles.
- Continuous input gives a continuous out_valid stream with out_sym_start every SPS cycles.
- No output backpressure: the downstream consumer accepts every out_valid sample.
- A symbol in flight is always completed. No symbol is ever truncated except by rstn.

## Test plan
- **Reset:** assert rstn=0 mid-SEND → out_valid=0, out_i=out_q=0, out_sym_start=0, in_ready=0 immediately (async). After release, in_ready=1 and the next transfer uses acc=0.
- **Single QPSK symbol** (SPS=4, DIFF_EN=0): bits 01 → 4 samples of (0, 32767) with out_sym_start on the first. Then out_valid=0 and in_ready=1.
- **Gray map:** QPSK bits 00, 01, 11, 10 streamed back-to-back → (32767,0), (0,32767), (-32767,0), (0,-32767).
  - 16 consecutive out_valid cycles with no gap.
  - in_ready pulses only on the last sample of each symbol.
- **8PSK** (BITS_PER_SYM=3): bits 001 → (23170, 23170); bits 100 (t=7) → (23170, -23170).
- **Differential** (DIFF_EN=1, QPSK): bits 01, 01, 01, 01, 00 → t=1,2,3,0,0 → (0,32767), (-32767,0), (0,-32767), (32767,0), (32767,0).
  - An idle gap inserted mid-sequence does not alter acc.
- **Handshake edges** (SPS=1): in_valid held high for 5 symbols → 5 consecutive samples, each with out_sym_start=1.
  - in_valid dropped for 1 cycle → one out_valid=0 cycle, then resumes.

Source files
------------

// File: rtl/mpsk_symbol_mapper_tx.sv
// mpsk_symbol_mapper_tx: Gray-coded MPSK mapper with optional differential
// encoding; each constellation point is held for SPS output samples.
module mpsk_symbol_mapper_tx #(
    parameter int DATA_WIDTH   = 16,
    parameter int BITS_PER_SYM = 2,
    parameter int SPS          = 4,
    parameter bit DIFF_EN      = 1'b0
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         in_valid,
    input  logic [BITS_PER_SYM-1:0]      in_bits,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_i,
    output logic signed [DATA_WIDTH-1:0] out_q,
    output logic                         out_sym_start
);
    localparam int CW = SPS > 1 ? $clog2(SPS) : 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;
    localparam logic [63:0] AMP = (64'd1 << (DATA_WIDTH - 1)) - 64'd1;

    // round(a/sqrt(2)) half-away-from-zero, done in integers so the LUT is exact
    function automatic logic [63:0] diag_amp(input logic [63:0] a);
        logic [63:0] x;
        x = '0;
        for (int b = 31; b >= 0; b--)
            if ((((x | (64'd1 << b)) * (x | (64'd1 << b))) << 1) <= a * a)
                x = x | (64'd1 << b);
        return ((a * a) << 1) >= (((x << 1) + 64'd1) * ((x << 1) + 64'd1)) ? x + 64'd1 : x;
    endfunction

    localparam logic signed [DATA_WIDTH-1:0] A = DATA_WIDTH'(AMP);
    localparam logic signed [DATA_WIDTH-1:0] D = DATA_WIDTH'(diag_amp(AMP));

    // sine of k*45 degrees; cosine is the same table advanced by two octants
    function automatic logic signed [DATA_WIDTH-1:0] sin8(input logic [2:0] k);
        logic signed [DATA_WIDTH-1:0] m;
        m = k[0] ? D : (k[1] ? A : '0);
        return k[2] ? -m : m;
    endfunction

    logic [0:0]                   state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [BITS_PER_SYM-1:0]      acc_q, acc_d, p, t;
    logic signed [DATA_WIDTH-1:0] i_q, i_d, q_q, q_d;
    logic [2:0]                   k;
    logic                         last, xfer;

    always_comb begin
        p = '0;
        for (int n = 0; n < BITS_PER_SYM; n++) p[n] = ^(in_bits >> n);
        t        = DIFF_EN ? acc_q + p : p;
        k        = 3'(t) << (3 - BITS_PER_SYM);
        last     = cnt_q == CW'(SPS - 1);
        in_ready = rstn && (state_q == IDLE || last);
        xfer     = in_valid && in_ready;
        state_d  = xfer ? SEND : (last ? IDLE : state_q);
        cnt_d    = (xfer || last) ? '0 : cnt_q + CW'(state_q == SEND);
        acc_d    = (xfer && DIFF_EN) ? t : acc_q;
        i_d      = xfer ? sin8(k + 3'd2) : (last ? '0 : i_q);
        q_d      = xfer ? sin8(k) : (last ? '0 : q_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            q_q     <= q_d;
        end
    end

    assign out_valid     = state_q == SEND;
    assign out_sym_start = out_valid && cnt_q == '0;
    assign out_i         = i_q;
    assign out_q         = q_q;
endmodule

// File: tb/tb_mpsk_symbol_mapper_tx.sv
// tb_mpsk_symbol_mapper_tx: four mapper configurations driven side by side and
// compared each cycle with a trigonometric reference model.
module tb_mpsk_symbol_mapper_tx;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic inv[4];
    logic [2:0] bits[4];
    logic ready[4], valid[4], start[4];
    logic signed [15:0] oi[4], oq[4];
    int checks = 0;
    int failures = 0;
    localparam int BPS[4]  = '{2, 3, 2, 2};
    localparam int SPSV[4] = '{4, 3, 2, 1};
    localparam int DIFF[4] = '{0, 0, 1, 1};
    int left[4], ci[4], cq[4], acc[4];
    int ei[4] = '{32767, 0, -32767, 0};
    int eq[4] = '{0, 32767, 0, -32767};
    int gseq[4] = '{0, 1, 3, 2};

    always #5 clk = ~clk;

    mpsk_symbol_mapper_tx #(.DATA_WIDTH(16), .BITS_PER_SYM(2), .SPS(4), .DIFF_EN(1'b0)) u0 (
        .clk(clk), .rstn(rstn), .in_valid(inv[0]), .in_bits(bits[0][1:0]), .in_ready(ready[0]),
        .out_valid(valid[0]), .out_i(oi[0]), .out_q(oq[0]), .out_sym_start(start[0]));
    mpsk_symbol_mapper_tx #(.DATA_WIDTH(16), .BITS_PER_SYM(3), .SPS(3), .DIFF_EN(1'b0)) u1 (
        .clk(clk), .rstn(rstn), .in_valid(inv[1]), .in_bits(bits[1]), .in_ready(ready[1]),
        .out_valid(valid[1]), .out_i(oi[1]), .out_q(oq[1]), .out_sym_start(start[1]));
    mpsk_symbol_mapper_tx #(.DATA_WIDTH(16), .BITS_PER_SYM(2), .SPS(2), .DIFF_EN(1'b1)) u2 (
        .clk(clk), .rstn(rstn), .in_valid(inv[2]), .in_bits(bits[2][1:0]), .in_ready(ready[2]),
        .out_valid(valid[2]), .out_i(oi[2]), .out_q(oq[2]), .out_sym_start(start[2]));
    mpsk_symbol_mapper_tx #(.DATA_WIDTH(16), .BITS_PER_SYM(2), .SPS(1), .DIFF_EN(1'b1)) u3 (
        .clk(clk), .rstn(rstn), .in_valid(inv[3]), .in_bits(bits[3][1:0]), .in_ready(ready[3]),
        .out_valid(valid[3]), .out_i(oi[3]), .out_q(oq[3]), .out_sym_start(start[3]));

    function automatic int rnd(real x);
        return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic int g2b(int g);
        int p = g;
        for (int s = g >> 1; s != 0; s = s >> 1) p = p ^ s;
        return p;
    endfunction

    task automatic chk(string tag, int k, logic signed [31:0] got, logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s u%0d got=%0d exp=%0d", tag, k, got, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk("valid", k, valid[k], left[k] > 0);
            chk("ready", k, ready[k], left[k] <= 1);
            chk("start", k, start[k], left[k] == SPSV[k]);
            chk("out_i", k, oi[k], left[k] > 0 ? ci[k] : 0);
            chk("out_q", k, oq[k], left[k] > 0 ? cq[k] : 0);
        end
    endtask

    task automatic check_reset(bit rdy);
        for (int k = 0; k < 4; k++) begin
            chk("rst_ready", k, ready[k], rdy);
            chk("rst_valid", k, valid[k], 0);
            chk("rst_start", k, start[k], 0);
            chk("rst_i", k, oi[k], 0);
            chk("rst_q", k, oq[k], 0);
        end
    endtask

    task automatic rst_model();
        for (int k = 0; k < 4; k++) begin
            left[k] = 0;
            acc[k] = 0;
        end
    endtask

    task automatic tick();
        bit x[4];
        int g[4];
        for (int k = 0; k < 4; k++) begin
            x[k] = inv[k] && left[k] <= 1;
            g[k] = int'(bits[k]) & ((1 << BPS[k]) - 1);
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            int m, t;
            real ang;
            if (left[k] > 0) left[k]--;
            if (x[k]) begin
                m = 1 << BPS[k];
                t = DIFF[k] != 0 ? (acc[k] + g2b(g[k])) % m : g2b(g[k]);
                acc[k] = t;
                ang = 2.0 * 3.14159265358979 * t / m;
                ci[k] = rnd(32767.0 * $cos(ang));
                cq[k] = rnd(32767.0 * $sin(ang));
                left[k] = SPSV[k];
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            inv[k] = 1'b0;
            bits[k] = '0;
        end
        rst_model();
        @(negedge clk);
        @(negedge clk);
        check_reset(1'b0);
        rstn = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) chk("ready_after_release", k, ready[k], 1);
        // single QPSK symbol
        inv[0] = 1'b1;
        bits[0] = 3'b001;
        tick();
        inv[0] = 1'b0;
        chk("qpsk01_i", 0, oi[0], 0);
        chk("qpsk01_q", 0, oq[0], 32767);
        chk("qpsk01_start", 0, start[0], 1);
        repeat (4) tick();
        chk("qpsk_idle_valid", 0, valid[0], 0);
        chk("qpsk_idle_ready", 0, ready[0], 1);
        // Gray order streamed back-to-back
        inv[0] = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bits[0] = 3'(gseq[c / 4]);
            tick();
            chk("stream_valid", 0, valid[0], 1);
            chk("stream_ready", 0, ready[0], c % 4 == 3);
            if (c % 4 == 0) begin
                chk("gray_i", 0, oi[0], ei[c / 4]);
                chk("gray_q", 0, oq[0], eq[c / 4]);
            end
        end
        inv[0] = 1'b0;
        tick();
        // 8PSK diagonals
        inv[1] = 1'b1;
        bits[1] = 3'b001;
        tick();
        inv[1] = 1'b0;
        chk("8psk001_i", 1, oi[1], 23170);
        chk("8psk001_q", 1, oq[1], 23170);
        repeat (2) tick();
        inv[1] = 1'b1;
        bits[1] = 3'b100;
        tick();
        inv[1] = 1'b0;
        chk("8psk100_i", 1, oi[1], 23170);
        chk("8psk100_q", 1, oq[1], -23170);
        repeat (3) tick();
        // differential QPSK with an idle gap
        for (int j = 0; j < 5; j++) begin
            if (j == 2) repeat (3) tick();
            inv[2] = 1'b1;
            bits[2] = j == 4 ? 3'b000 : 3'b001;
            tick();
            inv[2] = 1'b0;
            chk("diff_i", 2, oi[2], ei[(j + 1) % 4 == 0 ? 0 : (j == 4 ? 0 : j + 1)]);
            chk("diff_q", 2, oq[2], eq[(j + 1) % 4 == 0 ? 0 : (j == 4 ? 0 : j + 1)]);
            tick();
        end
        // SPS=1 full rate, then a one-cycle hole
        inv[3] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            bits[3] = 3'($urandom);
            tick();
            chk("sps1_start", 3, start[3], 1);
        end
        inv[3] = 1'b0;
        tick();
        chk("sps1_hole", 3, valid[3], 0);
        inv[3] = 1'b1;
        repeat (3) tick();
        inv[3] = 1'b0;
        tick();
        // asynchronous reset mid-symbol; acc must restart from zero
        inv[0] = 1'b1;
        inv[2] = 1'b1;
        bits[0] = 3'($urandom);
        bits[2] = 3'b001;
        tick();
        inv[0] = 1'b0;
        inv[2] = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        check_reset(1'b0);
        rst_model();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check_reset(1'b1);
        inv[2] = 1'b1;
        bits[2] = 3'b001;
        tick();
        inv[2] = 1'b0;
        chk("acc_cleared_i", 2, oi[2], 0);
        chk("acc_cleared_q", 2, oq[2], 32767);
        tick();
        // randomized traffic, dense then sparse
        repeat (400) begin
            for (int k = 0; k < 4; k++) begin
                inv[k] = $urandom_range(0, 3) != 0;
                bits[k] = 3'($urandom);
            end
            tick();
        end
        repeat (200) begin
            for (int k = 0; k < 4; k++) begin
                inv[k] = $urandom_range(0, 3) == 0;
                bits[k] = 3'($urandom);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) inv[k] = 1'b0;
        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
